// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding the 16-bit instruction register over a valid/ready memory port.
// Define FETCH_COUNT_EN to add a saturating fetch_count output that counts committed writes.
module fetch_unit #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned RESET_PC   = 0,
   parameter int unsigned PC_STEP    = 2
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  stall,
   input  logic                  branch_taken,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] mem_rsp_data,
   output logic [DATA_WIDTH-1:0] ir_data,
   output logic                  ir_write,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic                  busy
`ifdef FETCH_COUNT_EN
   ,output logic [15:0]          fetch_count
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

   state_t                  state;
   state_t                  next_state;
   logic [ADDR_WIDTH-1:0]   pc;
   logic [ADDR_WIDTH-1:0]   pend_target;
   logic                    drop;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A redirect arriving together with the response discards that response as well.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (run) next_state = REQ;
         REQ:     if (mem_req_ready) next_state = WAIT;
         WAIT:    if (mem_rsp_valid) next_state = (drop || branch_taken) ? REQ : WRITE;
         WRITE:   if (branch_taken || !stall) next_state = run ? REQ : IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      mem_req_valid = (state == REQ);
      mem_addr      = pc;
      ir_write      = (state == WRITE) && !stall && !branch_taken;
      busy          = (state != IDLE);
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         pc          <= ADDR_WIDTH'(RESET_PC);
         pc_out      <= ADDR_WIDTH'(RESET_PC);
         ir_data     <= '0;
         drop        <= 1'b0;
         pend_target <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (branch_taken) pc <= branch_target;
            end
            REQ: begin
               if (branch_taken) begin
                  pc <= branch_target;
                  if (mem_req_ready) begin
                     drop        <= 1'b1;
                     pend_target <= branch_target;
                  end
               end
            end
            WAIT: begin
               if (mem_rsp_valid) begin
                  if (branch_taken) begin
                     pc   <= branch_target;
                     drop <= 1'b0;
                  end else if (drop) begin
                     pc   <= pend_target;
                     drop <= 1'b0;
                  end else begin
                     ir_data <= mem_rsp_data;
                     pc_out  <= pc;
                  end
               end else if (branch_taken) begin
                  drop        <= 1'b1;
                  pend_target <= branch_target;
               end
            end
            WRITE: begin
               if (branch_taken) pc <= branch_target;
               else if (!stall)  pc <= pc + ADDR_WIDTH'(PC_STEP);
            end
            default: ;
         endcase
      end
   end

`ifdef FETCH_COUNT_EN
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         fetch_count <= '0;
      end else if (ir_write && (fetch_count != 16'hFFFF)) begin
         fetch_count <= fetch_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stall/branch/ready traffic,
// with a monitor comparing every instruction write against a program-flow model.
module tb_fetch_unit;

   logic        CLK;
   logic        reset;
   logic        run;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [15:0] mem_addr;
   logic        mem_rsp_valid;
   logic [15:0] mem_rsp_data;
   logic [15:0] ir_data;
   logic        ir_write;
   logic [15:0] pc_out;
   logic        busy;
`ifdef FETCH_COUNT_EN
   logic [15:0] fetch_count;
`endif

   int checks = 0;
   int failures = 0;
   int n_writes = 0;
   int n_since_reset = 0;

   logic [15:0] redir_q[$];
   logic [15:0] exp_pc = 16'h0000;

   int          fixed_delay = 0;
   logic        rand_ready = 1'b0;
   logic        acc_seen = 1'b0;
   logic [15:0] acc_addr = 16'h0000;
   logic        pend = 1'b0;
   logic [15:0] pend_addr = 16'h0000;
   int          rsp_cnt = 0;

   fetch_unit dut (
      .CLK(CLK),
      .reset(reset),
      .run(run),
      .stall(stall),
      .branch_taken(branch_taken),
      .branch_target(branch_target),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr),
      .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data(mem_rsp_data),
      .ir_data(ir_data),
      .ir_write(ir_write),
      .pc_out(pc_out),
      .busy(busy)
`ifdef FETCH_COUNT_EN
      ,.fetch_count(fetch_count)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Instruction memory contents as seen by the program.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (a == 16'h0000) return 16'h8888;
      if (a == 16'h0002) return 16'hDEAD;
      return (a * 16'd40503) ^ 16'h5A5A;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_req(input int max_cycles);
      int n = 0;
      @(negedge CLK);
      while (!mem_req_valid && n < max_cycles) begin
         @(negedge CLK);
         n++;
      end
      check_output("req_timeout", {31'b0, mem_req_valid}, 32'd1);
   endtask

   task automatic wait_write(input int max_cycles);
      int n = 0;
      @(negedge CLK);
      while (!ir_write && n < max_cycles) begin
         @(negedge CLK);
         n++;
      end
      check_output("write_timeout", {31'b0, ir_write}, 32'd1);
   endtask

   task automatic wait_idle(input int max_cycles);
      int n = 0;
      @(negedge CLK);
      while (busy && n < max_cycles) begin
         @(negedge CLK);
         n++;
      end
      check_output("idle_timeout", {31'b0, busy}, 32'd0);
   endtask

   task automatic issue_branch(input logic [15:0] target);
      branch_taken  = 1'b1;
      branch_target = target;
      redir_q.push_back(target);
   endtask

   // Randomized traffic: stalls, redirects and memory back-pressure.
   task automatic apply_stimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         next_cycle();
         stall        = ($urandom_range(0, 3) == 0);
         branch_taken = 1'b0;
         if ($urandom_range(0, 11) == 0) issue_branch(16'($urandom) & 16'hFFFE);
      end
      next_cycle();
      branch_taken = 1'b0;
      stall        = 1'b0;
      run          = 1'b0;
   endtask

   // Memory responder: accepts handshakes and returns one response after a delay.
   always @(negedge CLK) begin
      acc_seen = reset && mem_req_valid && mem_req_ready;
      acc_addr = mem_addr;
   end

   initial begin
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 16'h0000;
      forever begin
         @(posedge CLK);
         #1;
         mem_rsp_valid = 1'b0;
         if (acc_seen) begin
            pend      = 1'b1;
            pend_addr = acc_addr;
            rsp_cnt   = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 2));
         end
         if (pend) begin
            if (rsp_cnt == 0) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_data  = mem_word(pend_addr);
               pend          = 1'b0;
            end else begin
               rsp_cnt--;
            end
         end
         mem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: each write must be the next sequential instruction, or the latest redirect target.
   always @(negedge CLK) begin
      if (!reset) begin
         exp_pc = 16'h0000;
         n_since_reset = 0;
         redir_q.delete();
      end else if (ir_write) begin
         if (redir_q.size() > 0) begin
            exp_pc = redir_q[$];
            redir_q.delete();
         end
         check_output("write_pc", {16'b0, pc_out}, {16'b0, exp_pc});
         check_output("write_data", {16'b0, ir_data}, {16'b0, mem_word(exp_pc)});
`ifdef FETCH_COUNT_EN
         check_output("fetch_count", {16'b0, fetch_count}, 32'(n_since_reset));
`endif
         exp_pc = exp_pc + 16'd2;
         n_writes++;
         n_since_reset++;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int w0;
      int win_writes;
      reset         = 1'b0;
      run           = 1'b0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 16'h0000;

      // Reset values
      repeat (2) @(negedge CLK);
      check_output("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
      check_output("rst_ir_write", {31'b0, ir_write}, 32'd0);
      check_output("rst_busy", {31'b0, busy}, 32'd0);
      check_output("rst_pc_out", {16'b0, pc_out}, 32'h0);
      check_output("rst_ir_data", {16'b0, ir_data}, 32'h0);
      check_output("rst_mem_addr", {16'b0, mem_addr}, 32'h0);

      // Basic fetch from address 0
      next_cycle();
      reset = 1'b1;
      run   = 1'b1;
      wait_req(10);
      check_output("first_addr", {16'b0, mem_addr}, 32'h0);
      wait_write(10);
      check_output("first_data", {16'b0, ir_data}, 32'h8888);
      @(negedge CLK);
      check_output("one_pulse", {31'b0, ir_write}, 32'd0);
      check_output("second_req", {31'b0, mem_req_valid}, 32'd1);
      check_output("second_addr", {16'b0, mem_addr}, 32'h2);
      next_cycle();
      run = 1'b0;
      wait_idle(20);

      // Stall held in WRITE
      next_cycle();
      reset = 1'b0;
      next_cycle();
      reset = 1'b1;
      stall = 1'b1;
      run   = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge CLK);
         check_output("stall_no_write", {31'b0, ir_write}, 32'd0);
         if (i >= 3) check_output("stall_data", {16'b0, ir_data}, 32'h8888);
      end
      fixed_delay = 3;
      next_cycle();
      stall = 1'b0;
      @(negedge CLK);
      check_output("release_write", {31'b0, ir_write}, 32'd1);
      @(negedge CLK);
      check_output("release_single", {31'b0, ir_write}, 32'd0);
      check_output("after_stall_addr", {16'b0, mem_addr}, 32'h2);

      // Redirect while the 16'hDEAD response is still pending
      next_cycle();
      issue_branch(16'h0040);
      next_cycle();
      branch_taken = 1'b0;
      win_writes = 0;
      for (int i = 0; i < 12 && !mem_req_valid; i++) begin
         @(negedge CLK);
         if (ir_write) win_writes++;
      end
      check_output("drop_no_write", 32'(win_writes), 32'd0);
      check_output("redirect_addr", {16'b0, mem_addr}, 32'h40);
      fixed_delay = 0;
      wait_write(10);
      check_output("redirect_data", {16'b0, ir_data}, {16'b0, mem_word(16'h0040)});
      next_cycle();
      run = 1'b0;
      wait_idle(20);

      // PC wrap
      next_cycle();
      issue_branch(16'hFFFE);
      next_cycle();
      branch_taken = 1'b0;
      run = 1'b1;
      wait_write(10);
      check_output("wrap_pc_out", {16'b0, pc_out}, 32'hFFFE);
      @(negedge CLK);
      check_output("wrap_addr", {16'b0, mem_addr}, 32'h0);
      next_cycle();
      run = 1'b0;
      wait_idle(20);

      // Reset mid-WAIT with a stray response afterwards
      fixed_delay = 3;
      next_cycle();
      run = 1'b1;
      wait_req(10);
      next_cycle();
      reset = 1'b0;
      run   = 1'b0;
      next_cycle();
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         check_output("mid_rst_write", {31'b0, ir_write}, 32'd0);
         check_output("mid_rst_busy", {31'b0, busy}, 32'd0);
         check_output("mid_rst_req", {31'b0, mem_req_valid}, 32'd0);
         check_output("mid_rst_pc_out", {16'b0, pc_out}, 32'h0);
         check_output("mid_rst_ir_data", {16'b0, ir_data}, 32'h0);
      end

      // Randomized traffic
      fixed_delay = -1;
      rand_ready  = 1'b1;
      w0 = n_writes;
      next_cycle();
      run = 1'b1;
      apply_stimulus(800);
      wait_idle(40);
      check_output("rand_progress", {31'b0, (n_writes - w0) >= 20}, 32'd1);

      repeat (2) @(negedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the 16-bit instruction Register.
- Holds the PC and issues valid/ready read requests to instruction memory.
- Captures the returned word and drives it, with a one-cycle write strobe, into the Register's reg_input/reg_write.
- Supports branch redirect: an in-flight fetch is discarded and fetching restarts at the target.

Parameters:
- DATA_WIDTH, 16, instruction word width.
- ADDR_WIDTH, 16, PC/address width.
- RESET_PC, 0, PC value after reset.
- PC_STEP, 2, PC increment per fetched instruction.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- run  input  1  1 = fetch continuously; 0 = stop at the next instruction boundary.
- stall  input  1  downstream not ready; holds the write strobe off.
- branch_taken  input  1  one-cycle redirect pulse.
- branch_target  input  ADDR_WIDTH  redirect address.
- mem_req_valid  output  1  read request valid.
- mem_req_ready  input  1  memory accepts the request.
- mem_addr  output  ADDR_WIDTH  request address.
- mem_rsp_valid  input  1  read data valid (one-cycle pulse).
- mem_rsp_data  input  DATA_WIDTH  read data.
- ir_data  output  DATA_WIDTH  to Register reg_input.
- ir_write  output  1  to Register reg_write.
- pc_out  output  ADDR_WIDTH  address of the instruction in ir_data.
- busy  output  1  1 when state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, pc=RESET_PC, pc_out=RESET_PC, ir_data=0, ir_write=0, mem_req_valid=0, drop=0, pend_target=0.
  - Reset mid-fetch abandons the request; any later rsp_valid while in IDLE is ignored.
- States: IDLE, REQ, WAIT, WRITE.
- IDLE:
  - run=1 -> REQ on the next edge.
  - branch_taken -> pc<=branch_target, no fetch.
- REQ:
  - mem_req_valid=1, mem_addr=pc.
  - mem_addr is held stable until mem_req_ready=1 is sampled -> WAIT.
- WAIT:
  - mem_req_valid=0.
  - On mem_rsp_valid with drop=0: ir_data<=mem_rsp_data, pc_out<=pc -> WRITE.
  - On mem_rsp_valid with drop=1: discard the data, pc<=pend_target, drop<=0 -> REQ.
- WRITE:
  - ir_write=1 combinationally when stall=0; ir_data is stable the whole time in WRITE.
  - Edge with stall=0: pc<=pc+PC_STEP (mod 2^ADDR_WIDTH, wraps silently); next state REQ if run=1, else IDLE.
  - stall=1: remain in WRITE, ir_write=0.
- Redirect rules:
  - branch_taken in REQ: pc<=branch_target, and the address changes only if ready was not sampled that same cycle. If mem_req_ready=1 in that same cycle, treat the request as accepted: drop<=1, pend_target<=target -> WAIT.
  - branch_taken in WAIT: drop<=1, pend_target<=branch_target.
  - branch_taken in WRITE: ir_write is suppressed that cycle, pc<=branch_target, next state REQ (if run=1) or IDLE.
  - A second branch_taken while drop=1 overwrites pend_target; the last redirect wins.
- Latency: req accepted at edge N, rsp at edge N+k -> ir_write high during the cycle after N+k. Minimum fetch-to-fetch is 3 cycles.
- run deasserted in REQ/WAIT: the current fetch completes through WRITE, then IDLE.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined: adds output fetch_count [15:0], reset to 0.
  - Increments on each cycle with ir_write=1.
  - Saturates at 16'hFFFF.
  - Dropped fetches are not counted.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then run=1, memory ready=1, 1-cycle response returning 16'h8888 at addr 0 -> mem_addr=0, ir_data=16'h8888, ir_write one cycle, next mem_addr=2.
- stall=1 held 4 cycles in WRITE -> ir_write=0 throughout, ir_data=16'h8888 stable; stall=0 -> exactly one ir_write pulse, pc=2.
- branch_taken with target 16'h0040 during WAIT (response 16'hDEAD pending) -> 16'hDEAD never written, next mem_addr=16'h0040, ir_write stays 0 until the new data returns.
- pc=16'hFFFE, fetch completes -> next mem_addr=16'h0000 (wrap).
- reset=0 pulsed mid-WAIT, then a stray mem_rsp_valid arrives -> all outputs at reset values, busy=0, no ir_write.
- FETCH_COUNT_EN: 5 fetches plus 1 dropped -> fetch_count=5.
